// File: rtl/riscv_test_controller_if.sv
// riscv_test_controller_if
// Bundles the core-side signals seen by the run controller.
//   master : bench or wrapper side; drives the snooped core signals
//            (mem_we, mem_addr, mem_wdata, pc) and observes the verdict.
//   slave  : the controller; samples the snooped signals and drives
//            core_rst, status, done, pass, fail_code and cycle_count.
interface riscv_test_controller_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [XLEN-1:0]  pc;
  logic             core_rst;
  logic [2:0]       status;
  logic             done;
  logic             pass;
  logic [XLEN-1:0]  fail_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output mem_we, mem_addr, mem_wdata, pc,
    input  core_rst, status, done, pass, fail_code, cycle_count
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, pc,
    output core_rst, status, done, pass, fail_code, cycle_count
  );
endinterface

// File: rtl/riscv_test_controller.sv
// riscv_test_controller
// Sequences the core reset, counts RUN cycles and produces a pass/fail
// verdict from a store to the tohost word, a cycle timeout or a PC hang.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (clears everything)
//   bus  : slave modport; inputs mem_we/mem_addr/mem_wdata/pc snooped from
//          the core, outputs core_rst, status (0 RESET_HOLD, 1 RUN, 2 PASS,
//          3 FAIL, 4 TIMEOUT, 5 HANG), done, pass, fail_code, cycle_count.
module riscv_test_controller #(
  parameter int          RST_CYCLES     = 1,
  parameter int          TIMEOUT_CYCLES = 52,
  parameter int          HANG_CYCLES    = 16,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0400,
  parameter int          XLEN           = 32,
  parameter int          CNT_W          = 32
) (
  input logic                    clk,
  input logic                    rst,
  riscv_test_controller_if.slave bus
);

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam int HANG_W = (HANG_CYCLES < 3) ? 1 : $clog2(HANG_CYCLES);
  // When the counter saturates before the timeout value it can never match.
  localparam bit TIMEOUT_REACHABLE =
    (CNT_W >= 31) || ((TIMEOUT_CYCLES - 1) < (1 << CNT_W));

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_RUN        = 3'd1,
    ST_PASS       = 3'd2,
    ST_FAIL       = 3'd3,
    ST_TIMEOUT    = 3'd4,
    ST_HANG       = 3'd5
  } state_t;

  state_t            state_reg,     state_next;
  logic [HOLD_W-1:0] hold_cnt_reg,  hold_cnt_next;
  logic [CNT_W-1:0]  cycle_cnt_reg, cycle_cnt_next;
  logic [HANG_W-1:0] hang_cnt_reg,  hang_cnt_next;
  logic [XLEN-1:0]   prev_pc_reg,   prev_pc_next;
  logic [XLEN-1:0]   fail_code_reg, fail_code_next;

  logic tohost_store;
  logic pc_match;
  logic timeout_hit;
  logic hang_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RESET_HOLD;
      hold_cnt_reg  <= '0;
      cycle_cnt_reg <= '0;
      hang_cnt_reg  <= '0;
      prev_pc_reg   <= '0;
      fail_code_reg <= '0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      cycle_cnt_reg <= cycle_cnt_next;
      hang_cnt_reg  <= hang_cnt_next;
      prev_pc_reg   <= prev_pc_next;
      fail_code_reg <= fail_code_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_cnt_next  = hold_cnt_reg;
    cycle_cnt_next = cycle_cnt_reg;
    hang_cnt_next  = hang_cnt_reg;
    prev_pc_next   = prev_pc_reg;
    fail_code_next = fail_code_reg;

    tohost_store = bus.mem_we && (bus.mem_addr == XLEN'(TOHOST_ADDR));
    // cycle_cnt_reg is zero only on the first RUN cycle, whose PC merely
    // seeds prev_pc_reg and must not count as a repeat.
    pc_match     = (cycle_cnt_reg != '0) && (bus.pc == prev_pc_reg);
    timeout_hit  = TIMEOUT_REACHABLE &&
                   (cycle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    hang_hit     = pc_match && (hang_cnt_reg == HANG_W'(HANG_CYCLES - 2));

    case (state_reg)
      ST_RESET_HOLD: begin
        if (hold_cnt_reg == HOLD_W'(RST_CYCLES - 1)) begin
          state_next    = ST_RUN;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (cycle_cnt_reg != '1) begin
          cycle_cnt_next = cycle_cnt_reg + CNT_W'(1);
        end
        prev_pc_next  = bus.pc;
        hang_cnt_next = pc_match ? hang_cnt_reg + HANG_W'(1) : '0;
        // Even tohost values are not verdicts, so they fall through to the
        // timeout and hang checks like any other cycle.
        if (tohost_store && bus.mem_wdata[0]) begin
          if (bus.mem_wdata == XLEN'(1)) begin
            state_next = ST_PASS;
          end else begin
            state_next     = ST_FAIL;
            fail_code_next = bus.mem_wdata >> 1;
          end
        end else if (timeout_hit) begin
          state_next = ST_TIMEOUT;
        end else if (hang_hit) begin
          state_next = ST_HANG;
        end
      end
      default: begin
        // Terminal verdicts hold until rst.
        state_next = state_reg;
      end
    endcase
  end

  // core_rst is released in terminal states so the core can be inspected.
  assign bus.core_rst    = (state_reg == ST_RESET_HOLD);
  assign bus.status      = state_reg;
  assign bus.done        = (state_reg == ST_PASS) || (state_reg == ST_FAIL) ||
                           (state_reg == ST_TIMEOUT) || (state_reg == ST_HANG);
  assign bus.pass        = (state_reg == ST_PASS);
  assign bus.fail_code   = fail_code_reg;
  assign bus.cycle_count = cycle_cnt_reg;

endmodule

// File: tb/tb_riscv_test_controller.sv
module tb_riscv_test_controller;
  localparam int          XLEN    = 32;
  localparam int          CNT_W   = 32;
  localparam int          RSTC    = 1;
  localparam int          TMO     = 52;
  localparam int          HANGC   = 16;
  localparam logic [31:0] TOHOST  = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_test_controller_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  riscv_test_controller #(
    .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO), .HANG_CYCLES(HANGC),
    .TOHOST_ADDR(TOHOST), .XLEN(XLEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: tracks the verdict from the observed history.
  int          m_phase = 0;   // status code the controller must show
  int          m_low   = 0;   // edges seen with rst low while holding
  int          m_count = 0;   // RUN edges taken
  int          m_streak = 0;  // consecutive repeats of the PC
  bit          m_have_pc = 0;
  logic [31:0] m_last_pc = 0;
  logic [31:0] m_fail = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_low = 0; m_count = 0; m_streak = 0;
      m_have_pc = 0; m_fail = 0;
    end else if (m_phase == 0) begin
      m_low++;
      if (m_low == RSTC) m_phase = 1;
    end else if (m_phase == 1) begin
      m_count++;
      m_streak = (m_have_pc && bus.pc == m_last_pc) ? m_streak + 1 : 0;
      m_last_pc = bus.pc;
      m_have_pc = 1;
      if (bus.mem_we && bus.mem_addr == TOHOST && bus.mem_wdata == 32'd1)
        m_phase = 2;
      else if (bus.mem_we && bus.mem_addr == TOHOST && bus.mem_wdata[0]) begin
        m_phase = 3;
        m_fail  = bus.mem_wdata >> 1;
      end else if (m_count == TMO)
        m_phase = 4;
      else if (m_streak == HANGC - 1)
        m_phase = 5;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("status",      bus.status,      64'(m_phase));
      check("core_rst",    bus.core_rst,    64'(m_phase == 0));
      check("done",        bus.done,        64'(m_phase >= 2));
      check("pass",        bus.pass,        64'(m_phase == 2));
      check("fail_code",   bus.fail_code,   64'(m_fail));
      check("cycle_count", bus.cycle_count, 64'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scenario stimulus: up to three stores, and PC either incrementing by 4
  // or held at hold_val from RUN cycle hold_k onward (hold_k=0: never).
  int          st_k    [3];
  logic [31:0] st_addr [3];
  logic [31:0] st_data [3];

  task automatic clear_stores();
    for (int i = 0; i < 3; i++) begin
      st_k[i] = 0; st_addr[i] = 0; st_data[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.pc = '0;
    tick();
    tick();
    chk_en = 1'b1;
    check("lit_reset_status", bus.status, 64'd0);
    check("lit_reset_core_rst", bus.core_rst, 64'd1);
    check("lit_reset_count", bus.cycle_count, 64'd0);
    rst = 1'b0;
    tick();
    check("lit_run_status", bus.status, 64'd1);
    check("lit_run_core_rst", bus.core_rst, 64'd0);
  endtask

  task automatic run_seq(input int n, input int hold_k, input logic [31:0] hold_val);
    for (int k = 1; k <= n; k++) begin
      bus.pc = (hold_k != 0 && k >= hold_k) ? hold_val : 32'(4 * (k - 1));
      bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
      for (int i = 0; i < 3; i++) begin
        if (st_k[i] == k) begin
          bus.mem_we = 1'b1; bus.mem_addr = st_addr[i]; bus.mem_wdata = st_data[i];
        end
      end
      tick();
      if (k == 1) check("lit_first_count", bus.cycle_count, 64'd1);
    end
    bus.mem_we = 1'b0;
  endtask

  task automatic expect_end(input string name, input int status, input int count,
                            input logic [31:0] fcode);
    check({name, "_status"}, bus.status, 64'(status));
    check({name, "_count"}, bus.cycle_count, 64'(count));
    check({name, "_fail_code"}, bus.fail_code, 64'(fcode));
    $display("scenario %s: status=%0d cycle_count=%0d fail_code=%0h",
             name, bus.status, bus.cycle_count, bus.fail_code);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // PASS at cycle 10, later failing store ignored.
    clear_stores();
    st_k[0] = 10; st_addr[0] = TOHOST; st_data[0] = 32'd1;
    st_k[1] = 11; st_addr[1] = TOHOST; st_data[1] = 32'd7;
    do_reset();
    run_seq(14, 0, 0);
    expect_end("pass", 2, 10, 32'd0);
    check("pass_flag", bus.pass, 64'd1);

    // FAIL with code 3; even value and other address ignored first.
    clear_stores();
    st_k[0] = 3; st_addr[0] = TOHOST;          st_data[0] = 32'd4;
    st_k[1] = 4; st_addr[1] = TOHOST + 32'd4;  st_data[1] = 32'd1;
    st_k[2] = 6; st_addr[2] = TOHOST;          st_data[2] = 32'd7;
    do_reset();
    run_seq(9, 0, 0);
    expect_end("fail", 3, 6, 32'd3);
    check("fail_pass_flag", bus.pass, 64'd0);

    // TIMEOUT after exactly 52 RUN cycles.
    clear_stores();
    do_reset();
    run_seq(56, 0, 0);
    expect_end("timeout", 4, 52, 32'd0);

    // Store of 1 in the timeout cycle wins.
    clear_stores();
    st_k[0] = 52; st_addr[0] = TOHOST; st_data[0] = 32'd1;
    do_reset();
    run_seq(55, 0, 0);
    expect_end("pass_at_timeout", 2, 52, 32'd0);

    // PC held at 0x20 from cycle 5: 15th repeat on cycle 20.
    clear_stores();
    do_reset();
    run_seq(25, 5, 32'h20);
    expect_end("hang", 5, 20, 32'd0);

    // Failing store coinciding with the hang threshold wins.
    clear_stores();
    st_k[0] = 20; st_addr[0] = TOHOST; st_data[0] = 32'd9;
    do_reset();
    run_seq(25, 5, 32'h20);
    expect_end("store_over_hang", 3, 20, 32'd4);

    // Hang threshold on the timeout cycle: timeout wins.
    clear_stores();
    do_reset();
    run_seq(56, 37, 32'h1000);
    expect_end("timeout_over_hang", 4, 52, 32'd0);

    // rst pulse while in PASS restarts the sequence.
    clear_stores();
    st_k[0] = 3; st_addr[0] = TOHOST; st_data[0] = 32'd1;
    do_reset();
    run_seq(5, 0, 0);
    expect_end("pre_pulse", 2, 3, 32'd0);
    rst = 1'b1;
    tick();
    check("pulse_status", bus.status, 64'd0);
    check("pulse_core_rst", bus.core_rst, 64'd1);
    check("pulse_done", bus.done, 64'd0);
    check("pulse_count", bus.cycle_count, 64'd0);
    rst = 1'b0;
    tick();
    clear_stores();
    run_seq(3, 0, 0);
    expect_end("post_pulse", 1, 3, 32'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
